mem_block_responder: RTL and testbench

- Memory-side responder for the cache line-fill and write-back interface.
- Serves whole 64-byte line reads (allocate) and line writes (evict) after a fixed latency.
- Backing store is a line-granular array. Lines never written return a deterministic address pattern so fills can be checked.
- Sits between the cache controller's miss/evict path and the top-level test harness.

---
 rtl/mem_block_responder.sv | 159 +++++++++++++++
 tb/tb_mem_block_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// ============================================================================
// Module   : mem_block_responder
// Purpose  : Fixed-latency line-fill / write-back memory responder.
//            Optional out-of-range error reporting via `define RESP_ERR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_block_responder #(
  parameter int BLOCK_SIZE_BYTES = 64,
  parameter int OFFSET_BITS      = 6,
  parameter int LINE_IDX_BITS    = 8,
  parameter int MEM_DELAY        = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [31:0]                   req_addr,
  input  logic [BLOCK_SIZE_BYTES*8-1:0] req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [BLOCK_SIZE_BYTES*8-1:0] resp_rdata
`ifdef RESP_ERR_EN
  ,
  output logic                          resp_err
`endif
);

  localparam int c_line_w    = BLOCK_SIZE_BYTES * 8;
  localparam int c_words     = BLOCK_SIZE_BYTES / 4;
  localparam int c_mem_lines = 1 << LINE_IDX_BITS;
  localparam int c_delay     = (MEM_DELAY < 1) ? 1 : MEM_DELAY;
  localparam int c_cnt_w     = $clog2(c_delay + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                     r_state;
  logic [c_cnt_w-1:0]         r_cnt;
  logic                       r_we;
  logic [LINE_IDX_BITS-1:0]   r_idx;
  logic [31:0]                r_base;
  logic [c_line_w-1:0]        r_wdata;
  logic [c_mem_lines-1:0]     r_written;
  logic [c_line_w-1:0]        r_mem [0:c_mem_lines-1];
  logic [c_line_w-1:0]        w_pattern;
  logic                       w_done;
  logic                       w_err;
  logic                       w_mem_we;
  logic                       w_unused_addr;

  assign w_unused_addr = ^req_addr[OFFSET_BITS-1:0];
  assign w_done        = (r_cnt == c_cnt_w'(c_delay));

`ifdef RESP_ERR_EN
  logic r_err;
  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  // Unwritten lines read back as their own word addresses
  genvar k;
  generate
    for (k = 0; k < c_words; k++) begin : g_pattern
      assign w_pattern[32*k +: 32] = r_base + 32'(4 * k);
    end
  endgenerate

  assign w_mem_we = (r_state == S_WAIT) && w_done && r_we && !w_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_written  <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef RESP_ERR_EN
      r_err      <= 1'b0;
      resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_idx     <= req_addr[OFFSET_BITS +: LINE_IDX_BITS];
            r_base    <= {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            r_wdata   <= req_wdata;
            r_cnt     <= c_cnt_w'(1);
            req_ready <= 1'b0;
            r_state   <= S_WAIT;
`ifdef RESP_ERR_EN
            r_err     <= (req_addr[31:OFFSET_BITS+LINE_IDX_BITS] != '0);
`endif
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
`ifdef RESP_ERR_EN
            resp_err   <= r_err;
`endif
            if (r_we) begin
              resp_rdata <= '0;
              if (!w_err) begin
                r_written[r_idx] <= 1'b1;
              end
            end else if (w_err) begin
              resp_rdata <= '0;
            end else if (r_written[r_idx]) begin
              resp_rdata <= r_mem[r_idx];
            end else begin
              resp_rdata <= w_pattern;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
`ifdef RESP_ERR_EN
            resp_err   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_block_responder.sv
// ============================================================================
// Module   : tb_mem_block_responder
// Purpose  : Randomized self-checking bench for mem_block_responder against a
//            line-level reference model (honours `define RESP_ERR_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_block_responder;

  localparam int MEM_DELAY = 20;
  localparam int LW        = 512;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [LW-1:0] resp_rdata;
`ifdef RESP_ERR_EN
  logic          resp_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] mem_m [int];

  mem_block_responder #(
    .BLOCK_SIZE_BYTES(64),
    .OFFSET_BITS     (6),
    .LINE_IDX_BITS   (8),
    .MEM_DELAY       (MEM_DELAY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata)
`ifdef RESP_ERR_EN
    ,
    .resp_err  (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef RESP_ERR_EN
    return a[31:14] != 18'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Expected read data: stored line, else word k = line base + 4k
  function automatic logic [LW-1:0] model_line(input logic [31:0] a);
    logic [LW-1:0] r;
    logic [31:0]   base;
    if (mem_m.exists(int'(a[13:6]))) return mem_m[int'(a[13:6])];
    base = {a[31:6], 6'b0};
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = base + 32'(4 * w);
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic reset_dut();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b1;
    mem_m.delete();
    @(posedge clk); #1;
    chk("rst_release_ready", req_ready, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_ready", req_ready, 1);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [LW-1:0] wd,
                        input int hold, output logic [LW-1:0] got);
    logic [LW-1:0] exp;
    logic [LW-1:0] snap;
    bit            e;
    int            n;
    wait_ready();
    e   = addr_err(addr);
    exp = (we || e) ? '0 : model_line(addr);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = rand_line();
    chk("ready_drop", req_ready, 0);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, MEM_DELAY);
    chk("rdata", resp_rdata, exp);
`ifdef RESP_ERR_EN
    chk("resp_err", resp_err, e);
`endif
    got  = resp_rdata;
    snap = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, snap);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", resp_valid, 0);
    chk("done_req_ready", req_ready, 1);
    resp_ready = 1'b0;
    if (we && !e) mem_m[int'(addr[13:6])] = wd;
  endtask

  initial begin
    logic [LW-1:0] got;
    logic [LW-1:0] wd;
    logic [31:0]   a1;
    logic [31:0]   a2;
    int            k;
    bit            seen;

    reset_dut();

    // Pattern read of an unwritten line
    do_req(1'b0, 32'h0000_1040, '0, 0, got);
    chk("t1_word0", got[31:0], 32'h0000_1040);
    chk("t1_word15", got[511:480], 32'h0000_107C);

    // Write then read the same line at a different offset
    for (int w = 0; w < 16; w++) wd[w*32 +: 32] = 32'hA5A5_0000 + 32'(w);
    do_req(1'b1, 32'h0000_2000, wd, 0, got);
    chk("t2_wr_rdata", got, 0);
    do_req(1'b0, 32'h0000_2024, '0, 0, got);
    chk("t2_rd_line", got, wd);

    // Back-pressured response
    do_req(1'b0, 32'h0000_2000, '0, 7, got);

    // Reset during a write's wait period discards the write
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_3000; req_wdata = rand_line();
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t4_async_ready", req_ready, 0);
    chk("t4_async_valid", resp_valid, 0);
    chk("t4_async_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_m.delete();
    @(posedge clk); #1;
    chk("t4_release_ready", req_ready, 1);
    do_req(1'b0, 32'h0000_3000, '0, 0, got);
    chk("t4_word0", got[31:0], 32'h0000_3000);
    do_req(1'b0, 32'h0000_2000, '0, 0, got);
    chk("t4_no_stale_2000", got[31:0], 32'h0000_2000);

    // Continuous requests: only one in flight, spacing >= MEM_DELAY+2
    wait_ready();
    a1 = 32'h0000_4040;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a1; resp_ready = 1'b1;
    @(posedge clk); #1;
    k = 0; seen = 1'b0;
    while (k < 200) begin
      req_addr = {18'h0, 8'($urandom), 6'($urandom)};
      @(posedge clk); #1; k++;
      if (resp_valid && !seen) begin
        seen = 1'b1;
        chk("t5_lat", k, MEM_DELAY);
        chk("t5_first_data", resp_rdata, model_line(a1));
      end
      if (req_ready) break;
    end
    chk("t5_seen", seen, 1);
    a2 = {18'h0, 8'($urandom), 6'($urandom)};
    req_addr = a2;
    @(posedge clk); #1; k++;
    req_valid = 1'b0;
    chk("t5_spacing", (k >= MEM_DELAY + 2), 1);
    chk("t5_second_taken", req_ready, 0);
    k = 0;
    while (!resp_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("t5_second_data", resp_rdata, model_line(a2));
    @(posedge clk); #1;
    chk("t5_second_done", resp_valid, 0);
    resp_ready = 1'b0;

    // Upper address bits: error or alias to line 0
    do_req(1'b0, 32'h0001_0000, '0, 0, got);
`ifdef RESP_ERR_EN
    chk("t6_err_rdata", got, 0);
`else
    chk("t6_alias_word0", got[31:0], 32'h0001_0000);
`endif

    // Randomized mix over a few lines so reads hit earlier writes
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      logic [17:0] up;
      up = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'h0;
      a  = {up, 5'd0, 3'($urandom_range(0, 7)), 6'($urandom)};
      do_req(1'($urandom), a, rand_line(), $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
